// File: rtl/fsm_stim_sequencer.sv
// Table-driven stimulus sequencer: replays programmed (a,b) steps into the FSM and logs q per step.
// Optional SEQ_CHECK_EN adds an expected-response table, a mismatch counter and a pass flag.
module fsm_stim_sequencer #(
    parameter  int DEPTH = 16,
    parameter  int LAT   = 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [1:0]       wr_data,
    input  logic [AW:0]      len,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             a_out,
    output logic             b_out,
    input  logic             q_in,
    output logic [DEPTH-1:0] q_log
`ifdef SEQ_CHECK_EN
    ,
    input  logic             wr_exp,
    output logic [AW:0]      err_count,
    output logic             pass
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [DEPTH-1:0][1:0]  tbl_q, tbl_d;
    logic [AW:0]            len_q, len_d, len_c;
    logic [AW-1:0]          idx_q, idx_d, idx_nxt;
    logic [1:0]             drv_q, drv_d;
    logic [2:0]             drain_q, drain_d;
    logic                   tag_vld_d;
    logic [AW-1:0]          tag_idx_d;
    logic                   clr_log;
    logic                   wr_ok;
    // Stage 0 tags the step currently on a_out/b_out; stage LAT lines up with its q_in.
    logic [LAT:0]           pv_q;
    logic [LAT:0][AW-1:0]   pi_q;

    assign wr_ok   = (state_q == S_IDLE) && wr_en;
    assign len_c   = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
    assign idx_nxt = idx_q + 1'b1;
    assign busy    = (state_q != S_IDLE);
    assign a_out   = drv_q[1];
    assign b_out   = drv_q[0];

    always_comb begin
        tbl_d = tbl_q;
        if (wr_ok) begin
            tbl_d[wr_addr] = wr_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        drv_d     = 2'b00;
        drain_d   = drain_q;
        tag_vld_d = 1'b0;
        tag_idx_d = idx_q;
        clr_log   = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = len_c;
                    idx_d   = '0;
                    clr_log = 1'b1;
                    if (len_c != '0) begin
                        // Read through the write port so a same-cycle write is replayed.
                        state_d   = S_RUN;
                        drv_d     = tbl_d[0];
                        tag_vld_d = 1'b1;
                        tag_idx_d = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if ({1'b0, idx_q} == len_q - 1'b1) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end else begin
                    idx_d     = idx_nxt;
                    drv_d     = tbl_q[idx_nxt];
                    tag_vld_d = 1'b1;
                    tag_idx_d = idx_nxt;
                end
            end
            S_DRAIN: begin
                if (drain_q == 3'(LAT-1)) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            tbl_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            drv_q   <= '0;
            drain_q <= '0;
            pv_q    <= '0;
            pi_q    <= '0;
            q_log   <= '0;
        end else begin
            state_q <= state_d;
            tbl_q   <= tbl_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            drv_q   <= drv_d;
            drain_q <= drain_d;
            pv_q    <= {pv_q[LAT-1:0], tag_vld_d};
            pi_q    <= {pi_q[LAT-1:0], tag_idx_d};
            if (clr_log) begin
                q_log <= '0;
            end else if (pv_q[LAT]) begin
                q_log[pi_q[LAT]] <= q_in;
            end
        end
    end

`ifdef SEQ_CHECK_EN
    logic [DEPTH-1:0] exp_q;
    logic [AW:0]      err_q;

    assign err_count = err_q;
    assign pass      = (state_q == S_DONE) && (err_q == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            exp_q <= '0;
            err_q <= '0;
        end else begin
            if (wr_ok) begin
                exp_q[wr_addr] <= wr_exp;
            end
            if (clr_log) begin
                err_q <= '0;
            end else if (pv_q[LAT] && (q_in != exp_q[pi_q[LAT]])) begin
                err_q <= err_q + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/fsm_stim_sequencer.md
# fsm_stim_sequencer

Sequencer for the two-input, one-output Moore FSM block (inputs `a`, `b`, output `q`). It holds a small programmable table of (a, b) steps and replays them into the FSM one step per clock after a `start` pulse. It captures the FSM's `q` response for every step, realigned by a configurable pipeline latency. It sits between a host or bench controller and the FSM, replacing hand-timed stimulus with a single start/busy/done handshake.

## Interface
Parameters:
- `DEPTH`, 16: number of table entries; power of two, ≥2. `AW = $clog2(DEPTH)`.
- `LAT`, 1: cycles from a step being driven on `a_out`/`b_out` to the matching `q_in` being valid; range 1..4.

Ports:
- `clock`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `wr_en`  in  1  table write strobe; honoured only in IDLE.
- `wr_addr`  in  AW  table write index.
- `wr_data`  in  2  step value, {a, b}.
- `len`  in  AW+1  number of steps to play; sampled with `start`.
- `start`  in  1  run request; honoured only in IDLE.
- `busy`  out  1  high in RUN, DRAIN and DONE.
- `done`  out  1  one-cycle pulse when `q_log` is final.
- `a_out`, `b_out`  out  1 each  registered drive to FSM `a`, `b`.
- `q_in`  in  1  FSM `q`.
- `q_log`  out  DEPTH  bit k = captured response to step k.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `a_out`/`b_out` are 0.
  - Writes update `table[wr_addr]`.
  - `start` latches `len_l = min(len, DEPTH)`, clears `q_log` and the step index.
  - Next state is RUN if `len_l ≠ 0`, otherwise DONE.
- RUN:
  - Drives `table[idx]` on {`a_out`, `b_out`}, then increments `idx`.
  - After the step with `idx == len_l-1`, moves to DRAIN.
- DRAIN: drives 0/0 for exactly LAT cycles, then moves to DONE.
- DONE: `done` = 1 for one cycle, then IDLE.
- Capture:
  - A LAT-deep pipeline carries (valid, index) alongside each driven step.
  - When it emerges, `q_log[index] <= q_in`.
  - Entries ≥ `len_l` stay 0.
- Ignored inputs:
  - `wr_en` and `start` are ignored while `busy`.
  - Simultaneous `wr_en` and `start` in IDLE: the write completes, and the run uses the updated table.
- Reset:
  - Any state goes to IDLE.
  - `a_out`, `b_out`, `busy`, `done` = 0.
  - `q_log` = 0; table cleared to 0; capture pipeline flushed.
- Reset mid-run aborts with no `done` pulse.

## Timing
- `start` is sampled at edge T. Step k is on `a_out`/`b_out` during cycle T+1+k.
- `q_in` for step k is sampled at the end of cycle T+1+k+LAT.
- For N = `len_l` > 0:
  - RUN is cycles T+1..T+N.
  - DRAIN is T+N+1..T+N+LAT.
  - DONE (`done` = 1) is cycle T+N+LAT+1, with `q_log` final in that cycle.
  - IDLE resumes at T+N+LAT+2.
- `len` = 0: DONE in cycle T+1, `q_log` = 0.
- `busy` rises in cycle T+1 and falls with the return to IDLE.
- A new `start` is accepted in the first IDLE cycle.
- Write-to-read latency is 1 cycle; a write at edge W is visible to a run started at edge ≥ W.

## Configuration
- `SEQ_CHECK_EN` defined:
  - Adds input `wr_exp` (1 bit, written with `wr_data`) into a DEPTH-bit expected table.
  - Adds outputs `err_count` (AW+1 bits) and `pass` (1 bit).
  - Each capture with `q_in ≠ exp[index]` increments `err_count`.
  - `err_count` clears on accepted `start` and on reset.
  - `pass` = (`err_count` == 0), valid in the DONE cycle; `pass` = 0 outside DONE.
- `SEQ_CHECK_EN` undefined: these ports and the expected table do not exist. All other behaviour is identical.

## Test plan
- Loopback, LAT=1:
  - Bench models `q_in` as `a_out` delayed 1 cycle.
  - Table = {00,11,01,10,01,00,01,11,01}, `len` = 9, `start`.
  - Required: `q_log[8:0]` = 9'b010001010 (bit k = a of step k); `done` in cycle T+11; `busy` high for cycles T+1..T+11.
- `len` = 0:
  - `start` -> `done` in cycle T+1, `q_log` = 0, `a_out`/`b_out` stay 0.
- Clamp and latency:
  - LAT=3, `len` = 20 with DEPTH=16, all entries 11, `q_in` = `a_out` delayed 3 cycles.
  - Required: 16 steps driven; `q_log` = 16'hFFFF; `done` in cycle T+20.
- Busy guard:
  - During RUN, `wr_en` to entry 0 with 11 and a second `start`.
  - Required: table unchanged after the run; exactly one `done`.
- Mid-run reset:
  - `reset` at step 3 of a 9-step run -> next cycle IDLE, all outputs 0, `q_log` = 0, no `done`.
  - A fresh `start` then produces the full loopback result.
- `SEQ_CHECK_EN`:
  - Loopback run with `exp` = a-bits except bit 4 inverted.
  - Required: `err_count` = 1 and `pass` = 0 in the DONE cycle.
  - Rerun with the corrected `exp` -> `err_count` = 0, `pass` = 1.
